// File: rtl/audio_pkg.sv
// Shared constants for the audio output stage: codec register map,
// default sample width and underrun counter ceiling.
package audio_pkg;

  localparam logic [2:0] REG_PAUSE = 3'd1;
  localparam logic [2:0] REG_ATTEN = 3'd2;
  localparam logic [2:0] REG_MODE  = 3'd3;
  localparam logic [2:0] REG_CLR   = 3'd4;
  localparam logic [2:0] REG_FLUSH = 3'd5;

  localparam int SAMPLE_W_DEFAULT = 20;

  localparam logic [15:0] UNDERRUN_MAX = 16'hFFFF;

endpackage

// File: rtl/audio_frame_fifo.sv
// Single-clock frame FIFO with flush, simultaneous push/pop and registered
// full/empty/level flags. DEPTH must be a power of two.
module audio_frame_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic [AW:0]      count_next_s;
  logic             full_r;
  logic             empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  // A push into a full FIFO is only accepted when a pop frees a slot this cycle
  always_comb begin
    pop_ok_s     = pop & ~empty_r & ~flush;
    push_ok_s    = push & ~flush & (~full_r | pop_ok_s);
    count_next_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_next_s = count_r + (AW+1)'(1);
      2'b01:   count_next_s = count_r - (AW+1)'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Frame storage
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Pointers and registered occupancy flags
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == (AW+1)'(DEPTH));
      empty_r <= (count_next_s == '0);
    end
  end

  assign rdata = mem_r[rd_ptr_r];
  assign full  = full_r;
  assign empty = empty_r;
  assign level = count_r;

endmodule

// File: rtl/audio_stream_ctrl.sv
// Multi-channel audio output stage: frame FIFO, codec reset timer, request
// sync, pause/mono/flush and error accounting. Optional macro: AUDIO_ATTEN_EN.
module audio_stream_ctrl
  import audio_pkg::*;
#(
  parameter int SAMPLE_W     = SAMPLE_W_DEFAULT,
  parameter int CHANNELS     = 2,
  parameter int DEPTH        = 16,
  parameter int RESET_CYCLES = 4096
) (
  input  logic                         clk,
  input  logic                         global_reset,
  input  logic [CHANNELS*SAMPLE_W-1:0] pcm_data,
  input  logic                         wr_fifo,
  input  logic                         codec_ce,
  input  logic [2:0]                   codec_addr,
  input  logic [23:0]                  codec_data,
  input  logic                         cont_ready,
  output logic                         fifo_full,
  output logic                         fifo_empty,
  output logic [$clog2(DEPTH):0]       fifo_level,
  output logic                         audio_reset,
  output logic [CHANNELS*SAMPLE_W-1:0] frame_data,
  output logic                         frame_valid,
  output logic [15:0]                  underrun_cnt,
  output logic                         overflow,
  output logic                         paused
);

  localparam int FW = CHANNELS * SAMPLE_W;
  localparam int CW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);

  logic [CW-1:0]       rst_cnt_r;
  logic                audio_reset_r;
  logic [2:0]          sync_r;
  logic                req_r;
  logic                paused_r;
  logic                mono_r;
  logic [15:0]         underrun_r;
  logic                overflow_r;
  logic [FW-1:0]       frame_data_r;
  logic                frame_valid_r;
`ifdef AUDIO_ATTEN_EN
  logic [3:0]          atten_r;
`endif

  logic                flush_s;
  logic                clr_s;
  logic                req_act_s;
  logic                pop_s;
  logic                ovf_event_s;
  logic                fifo_full_s;
  logic                fifo_empty_s;
  logic [FW-1:0]       head_s;
  logic [FW-1:0]       proc_s;
  logic [SAMPLE_W-1:0] samp_s;

  audio_frame_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (global_reset),
    .flush (flush_s),
    .push  (wr_fifo),
    .pop   (req_act_s & ~paused_r),
    .wdata (pcm_data),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .level (fifo_level)
  );

  // Request qualification and register strobes
  always_comb begin
    flush_s     = codec_ce & (codec_addr == REG_FLUSH);
    clr_s       = codec_ce & (codec_addr == REG_CLR);
    req_act_s   = req_r & audio_reset_r;
    pop_s       = req_act_s & ~paused_r & ~fifo_empty_s;
    ovf_event_s = wr_fifo & fifo_full_s & ~pop_s & ~flush_s;
  end

  // Mono replication first, then optional signed attenuation per slot
  always_comb begin
    proc_s = '0;
    samp_s = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      if (mono_r) begin
        samp_s = head_s[SAMPLE_W-1:0];
      end else begin
        samp_s = head_s[c*SAMPLE_W +: SAMPLE_W];
      end
`ifdef AUDIO_ATTEN_EN
      proc_s[c*SAMPLE_W +: SAMPLE_W] = $signed(samp_s) >>> atten_r;
`else
      proc_s[c*SAMPLE_W +: SAMPLE_W] = samp_s;
`endif
    end
  end

  // Codec reset hold timer; audio_reset latches high once the count completes
  always_ff @(posedge clk) begin
    if (global_reset) begin
      rst_cnt_r     <= '0;
      audio_reset_r <= 1'b0;
    end else begin
      if (rst_cnt_r != RST_LAST) begin
        rst_cnt_r <= rst_cnt_r + CW'(1);
      end
      if (rst_cnt_r == RST_LAST) begin
        audio_reset_r <= 1'b1;
      end
    end
  end

  // Two-flop synchronizer plus registered rising-edge detect
  always_ff @(posedge clk) begin
    if (global_reset) begin
      sync_r <= 3'b000;
      req_r  <= 1'b0;
    end else begin
      sync_r <= {sync_r[1:0], cont_ready};
      req_r  <= sync_r[1] & ~sync_r[2];
    end
  end

  // Control registers and error accounting
  always_ff @(posedge clk) begin
    if (global_reset) begin
      paused_r   <= 1'b0;
      mono_r     <= 1'b0;
      underrun_r <= 16'd0;
      overflow_r <= 1'b0;
`ifdef AUDIO_ATTEN_EN
      atten_r    <= 4'd0;
`endif
    end else begin
      if (codec_ce) begin
        case (codec_addr)
          REG_PAUSE: begin
            if (codec_data == 24'd0) begin
              paused_r <= 1'b0;
            end else if (codec_data == 24'd1) begin
              paused_r <= 1'b1;
            end
          end
          REG_MODE:  mono_r  <= codec_data[0];
`ifdef AUDIO_ATTEN_EN
          REG_ATTEN: atten_r <= codec_data[3:0];
`endif
          default: ;
        endcase
      end
      if (clr_s) begin
        underrun_r <= 16'd0;
        overflow_r <= 1'b0;
      end else begin
        if (req_act_s && !paused_r && fifo_empty_s && (underrun_r != UNDERRUN_MAX)) begin
          underrun_r <= underrun_r + 16'd1;
        end
        if (ovf_event_s) begin
          overflow_r <= 1'b1;
        end
      end
    end
  end

  // Output frame register: zero frame on pause or underrun
  always_ff @(posedge clk) begin
    if (global_reset) begin
      frame_data_r  <= '0;
      frame_valid_r <= 1'b0;
    end else if (req_act_s) begin
      frame_valid_r <= 1'b1;
      frame_data_r  <= pop_s ? proc_s : '0;
    end else begin
      frame_valid_r <= 1'b0;
    end
  end

  assign fifo_full    = fifo_full_s;
  assign fifo_empty   = fifo_empty_s;
  assign audio_reset  = audio_reset_r;
  assign frame_data   = frame_data_r;
  assign frame_valid  = frame_valid_r;
  assign underrun_cnt = underrun_r;
  assign overflow     = overflow_r;
  assign paused       = paused_r;

endmodule

// File: tb/tb_audio_stream_ctrl.sv
// Scoreboard bench for audio_stream_ctrl (2 ch x 20 bit, DEPTH 4, 16-cycle codec reset).
module tb_audio_stream_ctrl;

  localparam int SW = 20;
  localparam int CH = 2;
  localparam int DP = 4;
  localparam int RC = 16;
  localparam int FW = SW * CH;

  logic          clk;
  logic          global_reset;
  logic [FW-1:0] pcm_data;
  logic          wr_fifo;
  logic          codec_ce;
  logic [2:0]    codec_addr;
  logic [23:0]   codec_data;
  logic          cont_ready;
  logic          fifo_full;
  logic          fifo_empty;
  logic [2:0]    fifo_level;
  logic          audio_reset;
  logic [FW-1:0] frame_data;
  logic          frame_valid;
  logic [15:0]   underrun_cnt;
  logic          overflow;
  logic          paused;

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] exp_q[$];

  audio_stream_ctrl #(
    .SAMPLE_W     (SW),
    .CHANNELS     (CH),
    .DEPTH        (DP),
    .RESET_CYCLES (RC)
  ) dut (
    .clk          (clk),
    .global_reset (global_reset),
    .pcm_data     (pcm_data),
    .wr_fifo      (wr_fifo),
    .codec_ce     (codec_ce),
    .codec_addr   (codec_addr),
    .codec_data   (codec_data),
    .cont_ready   (cont_ready),
    .fifo_full    (fifo_full),
    .fifo_empty   (fifo_empty),
    .fifo_level   (fifo_level),
    .audio_reset  (audio_reset),
    .frame_data   (frame_data),
    .frame_valid  (frame_valid),
    .underrun_cnt (underrun_cnt),
    .overflow     (overflow),
    .paused       (paused)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [FW-1:0] frm(input logic [SW-1:0] c1, input logic [SW-1:0] c0);
    return {c1, c0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [FW-1:0] d);
    pcm_data = d;
    wr_fifo  = 1'b1;
    tick();
    wr_fifo  = 1'b0;
  endtask

  task automatic reg_write(input logic [2:0] a, input logic [23:0] d);
    codec_ce   = 1'b1;
    codec_addr = a;
    codec_data = d;
    tick();
    codec_ce   = 1'b0;
  endtask

  // Raise cont_ready; frame must appear exactly 4 clk later for one cycle.
  // Optionally push a frame in the same cycle the request is serviced.
  task automatic request(input logic [FW-1:0] expv, input string name,
                         input bit push_with, input logic [FW-1:0] pd);
    logic [FW-1:0] e;
    exp_q.push_back(expv);
    cont_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (frame_valid !== 1'b0) begin
        errors++;
        $display("FAIL %s early_valid cycle %0d: got %b want 0", name, k, frame_valid);
      end
    end
    if (push_with) begin
      pcm_data = pd;
      wr_fifo  = 1'b1;
    end
    tick();
    wr_fifo = 1'b0;
    e = exp_q.pop_front();
    checks++;
    if (frame_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s valid: got %b want 1", name, frame_valid);
    end else begin
      checks++;
      if (frame_data !== e) begin
        errors++;
        $display("FAIL %s data: got %h want %h", name, frame_data, e);
      end
    end
    cont_ready = 1'b0;
    tick();
    checks++;
    if (frame_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s strobe_len: got %b want 0", name, frame_valid);
    end
    tick();
    tick();
  endtask

  task automatic test_reset();
    global_reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({fifo_full, fifo_empty, fifo_level, audio_reset, frame_valid, frame_data,
         underrun_cnt, overflow, paused} !== {1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 40'd0,
         16'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got full=%b empty=%b lvl=%0d ar=%b fv=%b fd=%h ur=%0d ov=%b p=%b want empty=1 rest 0",
               fifo_full, fifo_empty, fifo_level, audio_reset, frame_valid, frame_data,
               underrun_cnt, overflow, paused);
    end
    global_reset = 1'b0;
    for (int i = 1; i <= RC; i++) begin
      tick();
      if (i == 2) cont_ready = 1'b1;
      checks++;
      if (audio_reset !== ((i == RC) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL audio_reset_hold cycle %0d: got %b want %b", i, audio_reset, (i == RC));
      end
      checks++;
      if (frame_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_req_ignored cycle %0d: got %b want 0", i, frame_valid);
      end
    end
    repeat (4) begin
      tick();
      checks++;
      if (frame_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold_req_late: got %b want 0", frame_valid);
      end
    end
    cont_ready = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_fifo_order();
    push_frame(frm(20'h00002, 20'h00001));
    push_frame(frm(20'h00004, 20'h00003));
    checks++;
    if (fifo_level !== 3'd2) begin
      errors++;
      $display("FAIL order_level2: got %0d want 2", fifo_level);
    end
    request(frm(20'h00002, 20'h00001), "order_f0", 1'b0, '0);
    checks++;
    if (fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL order_level1: got %0d want 1", fifo_level);
    end
    request(frm(20'h00004, 20'h00003), "order_f1", 1'b0, '0);
    checks++;
    if ({fifo_level, fifo_empty} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL order_level0: got lvl=%0d empty=%b want 0/1", fifo_level, fifo_empty);
    end
  endtask

  task automatic test_pause();
    reg_write(3'd1, 24'd1);
    checks++;
    if (paused !== 1'b1) begin
      errors++;
      $display("FAIL pause_set: got %b want 1", paused);
    end
    push_frame(frm(20'h00006, 20'h00005));
    request('0, "pause_zero", 1'b0, '0);
    checks++;
    if ({fifo_level, underrun_cnt} !== {3'd1, 16'd0}) begin
      errors++;
      $display("FAIL pause_hold: got lvl=%0d ur=%0d want 1/0", fifo_level, underrun_cnt);
    end
    reg_write(3'd1, 24'd2);
    checks++;
    if (paused !== 1'b1) begin
      errors++;
      $display("FAIL pause_ignore_val: got %b want 1", paused);
    end
    reg_write(3'd1, 24'd0);
    request(frm(20'h00006, 20'h00005), "pause_resume", 1'b0, '0);
    checks++;
    if ({paused, fifo_level} !== {1'b0, 3'd0}) begin
      errors++;
      $display("FAIL pause_clear: got p=%b lvl=%0d want 0/0", paused, fifo_level);
    end
  endtask

  task automatic test_underrun();
    for (int i = 0; i < 3; i++) request('0, "underrun_zero", 1'b0, '0);
    checks++;
    if (underrun_cnt !== 16'd3) begin
      errors++;
      $display("FAIL underrun_cnt: got %0d want 3", underrun_cnt);
    end
    reg_write(3'd4, 24'd0);
    checks++;
    if (underrun_cnt !== 16'd0) begin
      errors++;
      $display("FAIL underrun_clr: got %0d want 0", underrun_cnt);
    end
  endtask

  task automatic test_back_to_back();
    wr_fifo = 1'b1;
    for (int i = 0; i <= DP; i++) begin
      pcm_data = frm(20'(32'h100 + i), 20'(32'h200 + i));
      tick();
    end
    wr_fifo = 1'b0;
    checks++;
    if ({fifo_full, overflow, fifo_level} !== {1'b1, 1'b1, 3'd4}) begin
      errors++;
      $display("FAIL overflow_state: got full=%b ov=%b lvl=%0d want 1/1/4", fifo_full, overflow, fifo_level);
    end
    reg_write(3'd4, 24'd0);
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clr: got %b want 0", overflow);
    end
    request(frm(20'h100, 20'h200), "full_pushpop", 1'b1, frm(20'hAAAAA, 20'h55555));
    checks++;
    if ({fifo_full, overflow, fifo_level} !== {1'b1, 1'b0, 3'd4}) begin
      errors++;
      $display("FAIL full_pushpop_lvl: got full=%b ov=%b lvl=%0d want 1/0/4", fifo_full, overflow, fifo_level);
    end
    for (int i = 1; i < DP; i++) begin
      request(frm(20'(32'h100 + i), 20'(32'h200 + i)), "drain", 1'b0, '0);
    end
    request(frm(20'hAAAAA, 20'h55555), "drain_last", 1'b0, '0);
    checks++;
    if (fifo_empty !== 1'b1) begin
      errors++;
      $display("FAIL drain_empty: got %b want 1", fifo_empty);
    end
  endtask

  task automatic test_flush();
    push_frame(frm(20'h00011, 20'h00010));
    push_frame(frm(20'h00013, 20'h00012));
    pcm_data   = frm(20'h00015, 20'h00014);
    wr_fifo    = 1'b1;
    codec_ce   = 1'b1;
    codec_addr = 3'd5;
    codec_data = 24'd0;
    tick();
    wr_fifo  = 1'b0;
    codec_ce = 1'b0;
    checks++;
    if ({fifo_level, fifo_empty} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL flush: got lvl=%0d empty=%b want 0/1", fifo_level, fifo_empty);
    end
    request('0, "flush_underrun", 1'b0, '0);
    checks++;
    if (underrun_cnt !== 16'd1) begin
      errors++;
      $display("FAIL flush_underrun_cnt: got %0d want 1", underrun_cnt);
    end
  endtask

  task automatic test_empty_push_req();
    request('0, "empty_pushreq", 1'b1, frm(20'h00021, 20'h00020));
    checks++;
    if ({fifo_level, underrun_cnt} !== {3'd1, 16'd2}) begin
      errors++;
      $display("FAIL empty_pushreq_state: got lvl=%0d ur=%0d want 1/2", fifo_level, underrun_cnt);
    end
    request(frm(20'h00021, 20'h00020), "empty_pushreq_pop", 1'b0, '0);
  endtask

  task automatic test_mono();
    reg_write(3'd3, 24'd1);
    push_frame(frm(20'h00000, 20'h7FFFF));
    request(frm(20'h7FFFF, 20'h7FFFF), "mono", 1'b0, '0);
`ifdef AUDIO_ATTEN_EN
    reg_write(3'd2, 24'd2);
    push_frame(frm(20'h00000, 20'h80000));
    request(frm(20'hE0000, 20'hE0000), "atten", 1'b0, '0);
    reg_write(3'd2, 24'd0);
`else
    reg_write(3'd2, 24'd2);
    push_frame(frm(20'h00000, 20'h80000));
    request(frm(20'h80000, 20'h80000), "atten_off", 1'b0, '0);
`endif
    reg_write(3'd3, 24'd0);
    push_frame(frm(20'h00003, 20'h80000));
    request(frm(20'h00003, 20'h80000), "stereo", 1'b0, '0);
  endtask

  task automatic test_mid_reset();
    push_frame(frm(20'h00009, 20'h00008));
    cont_ready = 1'b1;
    tick();
    tick();
    global_reset = 1'b1;
    tick();
    tick();
    global_reset = 1'b0;
    checks++;
    if ({fifo_level, fifo_empty, audio_reset} !== {3'd0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL midreset_state: got lvl=%0d empty=%b ar=%b want 0/1/0", fifo_level, fifo_empty, audio_reset);
    end
    for (int i = 0; i < RC + 4; i++) begin
      tick();
      checks++;
      if (frame_valid !== 1'b0) begin
        errors++;
        $display("FAIL midreset_suppress cycle %0d: got %b want 0", i, frame_valid);
      end
    end
    checks++;
    if (audio_reset !== 1'b1) begin
      errors++;
      $display("FAIL midreset_release: got %b want 1", audio_reset);
    end
    cont_ready = 1'b0;
    repeat (3) tick();
    request('0, "midreset_underrun", 1'b0, '0);
  endtask

  initial begin
    global_reset = 1'b1;
    pcm_data     = '0;
    wr_fifo      = 1'b0;
    codec_ce     = 1'b0;
    codec_addr   = 3'd0;
    codec_data   = 24'd0;
    cont_ready   = 1'b0;
    test_reset();
    test_fifo_order();
    test_pause();
    test_underrun();
    test_back_to_back();
    test_flush();
    test_empty_push_req();
    test_mono();
    test_mid_reset();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/audio_stream_ctrl.md
Name: audio_stream_ctrl

Overview:
- Parametrised successor to the single-stereo audio output stage.
- Buffers multi-channel PCM frames from the filter in a single-clock FIFO, holds the codec in reset for a programmable time, and hands one frame per codec frame request to the serializer.
- Adds pause/mute, mono-replicate mode, FIFO flush, and underrun/overflow accounting, all controlled over the MMU codec register bus.

Parameters:
- SAMPLE_W, 20, bits per channel sample
- CHANNELS, 2, channels per frame (1..8)
- DEPTH, 16, FIFO depth in frames (power of two, >=4)
- RESET_CYCLES, 4096, clk cycles audio_reset is held low after reset

Ports:
- clk  in  1  system clock
- global_reset  in  1  synchronous, active-high reset
- pcm_data  in  CHANNELS*SAMPLE_W  frame from filter; ch0 in LSBs
- wr_fifo  in  1  push strobe, one frame per cycle
- codec_ce  in  1  register write strobe
- codec_addr  in  3  register address
- codec_data  in  24  register write data
- cont_ready  in  1  frame-request level from codec controller (asynchronous)
- fifo_full  out  1  FIFO full
- fifo_empty  out  1  FIFO empty
- fifo_level  out  $clog2(DEPTH)+1  frames stored
- audio_reset  out  1  codec reset, active low
- frame_data  out  CHANNELS*SAMPLE_W  frame to serializer
- frame_valid  out  1  one-cycle strobe when frame_data updates
- underrun_cnt  out  16  saturating underrun count
- overflow  out  1  sticky: push attempted while full
- paused  out  1  pause state

Behaviour:
- Reset: synchronous on clk when global_reset=1. All outputs 0 except fifo_empty=1. FIFO pointers, mode, and attenuation are cleared.
- Reset timer: counts from 0 after reset. audio_reset=0 until the count reaches RESET_CYCLES-1, then audio_reset=1 permanently until the next reset. Frame requests are ignored while audio_reset=0.
- Request sync: cont_ready passes through a 2-flop synchronizer, then a rising-edge detect produces a req pulse. req appears 3 clk after cont_ready rises. frame_valid and frame_data update on the clk after req.
- Registers, written when codec_ce=1 (other addresses are ignored):
  - addr 1: data==0 clears pause; data==1 sets pause; other values ignored.
  - addr 3: bit0 sets mono mode.
  - addr 4: any write clears underrun_cnt and overflow.
  - addr 5: any write flushes the FIFO (pointers to 0). A push in the same cycle is dropped.
- Push: accepted when wr_fifo=1 and the FIFO is not full. If full and no pop occurs that cycle, the push is dropped and overflow is set.
- Full with simultaneous pop: the push is accepted and the level stays DEPTH.
- On req:
  - paused=1: no pop; frame_data<=0; frame_valid=1; no underrun counted.
  - not paused, FIFO not empty: pop head; frame_data<=processed head; frame_valid=1.
  - not paused, FIFO empty: frame_data<=0; frame_valid=1; underrun_cnt increments, saturating at 16'hFFFF.
- Empty with simultaneous push and req: counts as an underrun (no bypass). The pushed frame is stored.
- Mono mode: the output replicates ch0 into every channel slot.
- Pointers wrap modulo DEPTH. fifo_level, full, and empty are registered and update 1 clk after the push/pop.
- Reset asserted mid-operation discards FIFO contents and the next frame_valid is suppressed.

Optional Feature:
- Macro AUDIO_ATTEN_EN.
- Defined: addr 2 data[3:0] sets an attenuation shift A. Each output sample is arithmetic-shifted right by A (signed, sign-extended), applied after mono replication. Reset value A=0.
- Undefined: addr 2 is ignored and samples pass unmodified.

Decomposition:
- Shared package audio_pkg holds:
  - register address constants (REG_PAUSE=1, REG_ATTEN=2, REG_MODE=3, REG_CLR=4, REG_FLUSH=5)
  - default SAMPLE_W
  - UNDERRUN_MAX
- One natural sub-module: audio_frame_fifo. It is a single-clock FIFO parametrised by width and depth, with flush, full/empty/level outputs, and simultaneous push/pop.

Test Plan:
- Reset release with RESET_CYCLES=16 -> audio_reset=0 for 16 clk, then 1; a cont_ready rise during hold gives no frame_valid.
- Push frames 0x00001/0x00002, 0x00003/0x00004; raise cont_ready twice -> frame_data equals those frames in order, each 4 clk after the rise; fifo_level 2->1->0.
- Write addr1=1, push one frame, request -> frame_data=0, frame_valid=1, fifo_level stays 1; write addr1=0, request -> the frame pops.
- Three requests on an empty FIFO -> underrun_cnt=3 and outputs are zero; write addr4 -> underrun_cnt=0.
- Push DEPTH+1 frames back to back -> fifo_full=1, overflow=1, level=DEPTH; push and request in the same cycle -> level unchanged at DEPTH.
- Mono mode with ch0=0x7FFFF, ch1=0x00000 -> both slots 0x7FFFF; with AUDIO_ATTEN_EN and A=2, ch0=0x80000 -> 0xE0000.
